// File: rtl/pipe_flow_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_flow_ctrl : per-stage write-enable / sync-clear from stall, flush, drain
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_flow_ctrl #(
  parameter int NSTAGES    = 6,
  parameter int WDOG_W     = 8,
  parameter int WDOG_LIMIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSTAGES-1:0] stall_req,
  input  logic [NSTAGES-1:0] flush_req,
  input  logic               drain_req,
  output logic [NSTAGES-1:0] stage_we,
  output logic [NSTAGES-1:0] stage_rst,
  output logic               redirect,
  output logic               flush_pending,
  output logic               drained,
  output logic               stall_timeout
);

  localparam int IW = $clog2(NSTAGES);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     dcnt, dcnt_nxt, dcnt_inc;
  logic              pend_valid, pend_valid_nxt;
  logic [IW-1:0]     pend_idx, pend_idx_nxt;
  logic [WDOG_W-1:0] wcnt, wcnt_nxt;
  logic              timeout_flag;

  logic s_valid;
  int   s_idx;
  logic f_valid;
  int   f_idx;
  logic flush_apply;
  logic stall_eff;

  // Highest-index stall and flush; a latched flush competes with new ones.
  always_comb begin
    s_valid = 1'b0;
    s_idx   = 0;
    f_valid = 1'b0;
    f_idx   = 0;
    for (int k = 1; k < NSTAGES; k++) begin
      if (stall_req[k]) begin
        s_valid = 1'b1;
        s_idx   = k;
      end
      if (flush_req[k]) begin
        f_valid = 1'b1;
        f_idx   = k;
      end
    end
    if (pend_valid && (!f_valid || (int'(pend_idx) > f_idx))) begin
      f_valid = 1'b1;
      f_idx   = int'(pend_idx);
    end
  end

  assign flush_apply = f_valid && (!s_valid || (f_idx > s_idx));
  assign stall_eff   = s_valid && (state != DRAINED);

  always_comb begin
    stage_we  = '1;
    stage_rst = '0;
    redirect  = 1'b0;
    drained   = 1'b0;
    if (flush_apply) begin
      redirect = 1'b1;
      for (int k = 1; k < NSTAGES; k++) begin
        stage_rst[k] = (k <= f_idx);
      end
    end else if (s_valid) begin
      for (int k = 0; k < NSTAGES; k++) begin
        if (k <= s_idx) begin
          stage_we[k] = 1'b0;
        end else if (k == s_idx + 1) begin
          stage_rst[k] = 1'b1;
        end
      end
    end
    // Draining: starve fetch and keep pushing bubbles in behind the tail.
    if ((state == DRAIN) && !flush_apply) begin
      stage_we[0]  = 1'b0;
      stage_we[1]  = 1'b1;
      stage_rst[1] = 1'b1;
    end
    if (state == DRAINED) begin
      stage_we  = '0;
      stage_rst = '0;
      redirect  = 1'b0;
      drained   = 1'b1;
    end
    if (reset) begin
      stage_we  = '1;
      stage_rst = '1;
      redirect  = 1'b0;
      drained   = 1'b0;
    end
  end

  assign flush_pending = pend_valid & ~reset;
  assign stall_timeout = timeout_flag & ~reset;

  assign dcnt_inc = dcnt + 1'b1;

  always_comb begin
    state_nxt      = state;
    dcnt_nxt       = dcnt;
    pend_valid_nxt = pend_valid;
    pend_idx_nxt   = pend_idx;
    if (state != DRAINED) begin
      if (flush_apply) begin
        pend_valid_nxt = 1'b0;
      end else if (s_valid && f_valid) begin
        pend_valid_nxt = 1'b1;
        pend_idx_nxt   = f_idx[IW-1:0];
      end
    end
    case (state)
      RUN: begin
        if (drain_req) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end
      end
      DRAIN: begin
        if (!drain_req) begin
          state_nxt = RUN;
          dcnt_nxt  = '0;
        end else if (!s_valid) begin
          dcnt_nxt = dcnt_inc;
          if (dcnt_inc == IW'(NSTAGES - 1)) begin
            state_nxt = DRAINED;
          end
        end
      end
      DRAINED: begin
        if (!drain_req) begin
          state_nxt = RUN;
          dcnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        dcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    wcnt_nxt = '0;
    if (stall_eff) begin
      wcnt_nxt = (wcnt == '1) ? wcnt : wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      dcnt         <= '0;
      pend_valid   <= 1'b0;
      pend_idx     <= '0;
      wcnt         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_nxt;
      dcnt         <= dcnt_nxt;
      pend_valid   <= pend_valid_nxt;
      pend_idx     <= pend_idx_nxt;
      wcnt         <= wcnt_nxt;
      timeout_flag <= timeout_flag | (wcnt_nxt == WDOG_W'(WDOG_LIMIT));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_flow_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_flow_ctrl : directed vector bench for pipe_flow_ctrl (NSTAGES=6, WDOG_LIMIT=4)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipe_flow_ctrl;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] stall_req = '0;
  logic [N-1:0] flush_req = '0;
  logic         drain_req = 1'b0;
  logic [N-1:0] stage_we, stage_rst;
  logic         redirect, flush_pending, drained, stall_timeout;

  int errors = 0;
  int checks = 0;
  int step   = 0;

  pipe_flow_ctrl #(.NSTAGES(N), .WDOG_W(8), .WDOG_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .stall_req(stall_req), .flush_req(flush_req), .drain_req(drain_req),
    .stage_we(stage_we), .stage_rst(stage_rst), .redirect(redirect),
    .flush_pending(flush_pending), .drained(drained), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_in;
    logic [N-1:0] stall;
    logic [N-1:0] flush;
    logic         drain;
    logic [N-1:0] we;
    logic [N-1:0] rs;
    logic         rd;
    logic         pd;
    logic         dr;
    logic         to;
  } vec_t;

  function automatic vec_t mk(logic r, logic [N-1:0] st, logic [N-1:0] fl, logic dn,
                              logic [N-1:0] we, logic [N-1:0] rs,
                              logic rd, logic pd, logic dr, logic to);
    vec_t v;
    v.rst_in = r; v.stall = st; v.flush = fl; v.drain = dn;
    v.we = we; v.rs = rs; v.rd = rd; v.pd = pd; v.dr = dr; v.to = to;
    return v;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %b expected %b", step, name, act, exp);
    end
  endtask

  // Drive one cycle just after the edge, compare at the falling edge.
  task automatic cyc(input vec_t v);
    reset     = v.rst_in;
    stall_req = v.stall;
    flush_req = v.flush;
    drain_req = v.drain;
    #4;
    chk("stage_we", stage_we, v.we);
    chk("stage_rst", stage_rst, v.rs);
    chk("redirect", {5'b0, redirect}, {5'b0, v.rd});
    chk("flush_pending", {5'b0, flush_pending}, {5'b0, v.pd});
    chk("drained", {5'b0, drained}, {5'b0, v.dr});
    chk("stall_timeout", {5'b0, stall_timeout}, {5'b0, v.to});
    step++;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    // reset, stall, flush vs stall, pending flush, watchdog
    tbl.push_back(mk(1, 6'b000000, 6'b000000, 0, 6'b111111, 6'b111111, 0, 0, 0, 0));
    tbl.push_back(mk(1, 6'b000000, 6'b000000, 0, 6'b111111, 6'b111111, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b000000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'b000100, 6'b000000, 0, 6'b111000, 6'b001000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'b010000, 6'b001000, 0, 6'b100000, 6'b100000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'b010000, 6'b000000, 0, 6'b100000, 6'b100000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b001110, 1, 1, 0, 0));
    tbl.push_back(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b000000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'b000100, 6'b010000, 0, 6'b111111, 6'b011110, 1, 0, 0, 0));
    tbl.push_back(mk(0, 6'b000000, 6'b010100, 0, 6'b111111, 6'b011110, 1, 0, 0, 0));
    tbl.push_back(mk(0, 6'b100000, 6'b001000, 0, 6'b000000, 6'b000000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'b100000, 6'b000100, 0, 6'b000000, 6'b000000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b001110, 1, 1, 0, 0));
    tbl.push_back(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b000000, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 6'b001000, 6'b000000, 0, 6'b110000, 6'b010000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b000000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b000000, 0, 0, 0, 1));
    tbl.push_back(mk(1, 6'b000000, 6'b000000, 0, 6'b111111, 6'b111111, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b000000, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) cyc(tbl[i]);

    // Plain drain: five DRAIN cycles, then DRAINED, then back to RUN.
    cyc(mk(0, 6'b000000, 6'b000000, 1, 6'b111111, 6'b000000, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      cyc(mk(0, 6'b000000, 6'b000000, 1, 6'b111110, 6'b000010, 0, 0, 0, 0));
    cyc(mk(0, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 0, 0, 1, 0));
    cyc(mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 6'b000000, 0, 0, 1, 0));
    cyc(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b000000, 0, 0, 0, 0));

    // Drain with one stalled cycle: DRAINED arrives one cycle later.
    cyc(mk(0, 6'b000000, 6'b000000, 1, 6'b111111, 6'b000000, 0, 0, 0, 0));
    cyc(mk(0, 6'b000000, 6'b000000, 1, 6'b111110, 6'b000010, 0, 0, 0, 0));
    cyc(mk(0, 6'b000100, 6'b000000, 1, 6'b111010, 6'b001010, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      cyc(mk(0, 6'b000000, 6'b000000, 1, 6'b111110, 6'b000010, 0, 0, 0, 0));
    cyc(mk(0, 6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 0, 0, 1, 0));
    cyc(mk(0, 6'b000000, 6'b000000, 0, 6'b000000, 6'b000000, 0, 0, 1, 0));
    cyc(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b000000, 0, 0, 0, 0));

    // One-cycle drain pulse: one DRAIN cycle, then RUN.
    cyc(mk(0, 6'b000000, 6'b000000, 1, 6'b111111, 6'b000000, 0, 0, 0, 0));
    cyc(mk(0, 6'b000000, 6'b000000, 0, 6'b111110, 6'b000010, 0, 0, 0, 0));
    cyc(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b000000, 0, 0, 0, 0));

    // Reset mid-drain with a latched flush discards both.
    cyc(mk(0, 6'b000000, 6'b000000, 1, 6'b111111, 6'b000000, 0, 0, 0, 0));
    cyc(mk(0, 6'b100000, 6'b000100, 1, 6'b000010, 6'b000010, 0, 0, 0, 0));
    cyc(mk(1, 6'b000000, 6'b000000, 1, 6'b111111, 6'b111111, 0, 0, 0, 0));
    cyc(mk(0, 6'b000000, 6'b000000, 0, 6'b111111, 6'b000000, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
